// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Optional multiply-accumulate ops 7-10 are enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    mul_res;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] dvd_n;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   t;
  logic             ge;
  logic             sq;
  logic             sr;
  logic             dz;
  logic             go;
  logic             is_mul;
  logic             is_div;
  logic             sgn_mul;
  logic             sgn_div;
`ifdef MD_MADD_EN
  logic [3:0]       mop;
`endif

  assign busy    = (state_q != IDLE);
  assign go      = start & ~cancel & (state_q == IDLE);
  assign is_div  = (op == 4'd3) || (op == 4'd4);
  assign sgn_mul = (op == 4'd1) || (op == 4'd7) || (op == 4'd9);
  assign sgn_div = (op == 4'd3);

  // Decode which ops run through the multiplier path
  always_comb begin
    is_mul = (op == 4'd1) || (op == 4'd2);
`ifdef MD_MADD_EN
    is_mul = is_mul || ((op >= 4'd7) && (op <= 4'd10));
`endif
  end

  // Value committed to {HI,LO} when a multiply completes
  always_comb begin
    mul_res = prod;
`ifdef MD_MADD_EN
    if ((mop == 4'd7) || (mop == 4'd8))
      mul_res = {hi, lo} + prod;
    else if ((mop == 4'd9) || (mop == 4'd10))
      mul_res = {hi, lo} - prod;
`endif
  end

  // One restoring-division step plus final sign fix-up
  always_comb begin
    t     = {rem, dvd[WIDTH-1]};
    ge    = (t >= {1'b0, dvs});
    rem_n = ge ? (t[WIDTH-1:0] - dvs) : t[WIDTH-1:0];
    dvd_n = {dvd[WIDTH-2:0], ge};
    q_fix = dz ? '1 : (sq ? -dvd : dvd);
    r_fix = sr ? -rem : rem;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go && is_mul)
          state_d = MUL;
        else if (go && is_div)
          state_d = DIV;
      end
      MUL: begin
        if (cancel || (cnt == '0))
          state_d = IDLE;
      end
      DIV: begin
        if (cancel)
          state_d = IDLE;
        else if (cnt == '0)
          state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Datapath: operand latch, iteration and HI/LO commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      prod <= '0;
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      sq   <= 1'b0;
      sr   <= 1'b0;
      dz   <= 1'b0;
`ifdef MD_MADD_EN
      mop  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            if (is_mul) begin
              prod <= (sgn_mul ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs})
                    * (sgn_mul ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt});
              cnt  <= CW'(MULT_CYCLES - 1);
`ifdef MD_MADD_EN
              mop  <= op;
`endif
            end else if (is_div) begin
              sq  <= sgn_div && (rs[WIDTH-1] ^ rt[WIDTH-1]);
              sr  <= sgn_div && rs[WIDTH-1];
              dvd <= (sgn_div && rs[WIDTH-1]) ? -rs : rs;
              dvs <= (sgn_div && rt[WIDTH-1]) ? -rt : rt;
              dz  <= (rt == '0);
              rem <= '0;
              cnt <= CW'(WIDTH - 1);
            end else if (op == 4'd5) begin
              hi <= rs;
            end else if (op == 4'd6) begin
              lo <= rs;
            end
          end
        end
        MUL: begin
          if (!cancel) begin
            if (cnt != '0)
              cnt <= cnt - 1'b1;
            else
              {hi, lo} <= mul_res;
          end
        end
        DIV: begin
          if (!cancel) begin
            rem <= rem_n;
            dvd <= dvd_n;
            if (cnt != '0)
              cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!cancel) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Random ops are checked against an arithmetic HI/LO reference model.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cancel;
  logic [3:0]   op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: updates m_hi/m_lo, returns expected busy cycles
  function automatic int model(input logic [3:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     acc = {m_hi, m_lo};
    logic [63:0]     p;
    longint          q;
    longint          r;
    bit              acc_en = 1'b0;
`ifdef MD_MADD_EN
    acc_en = 1'b1;
`endif
    if (o == 1 || o == 2 || (acc_en && o >= 7 && o <= 10)) begin
      if (o == 1 || o == 7 || o == 9)
        p = 64'(sa * sb);
      else
        p = 64'(ua * ub);
      if (o == 7 || o == 8)
        acc = acc + p;
      else if (o == 9 || o == 10)
        acc = acc - p;
      else
        acc = p;
      m_hi = acc[63:32];
      m_lo = acc[31:0];
      return MC;
    end
    if (o == 3 || o == 4) begin
      if (b == 0) begin
        m_lo = '1;
        m_hi = a;
      end else if (o == 3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = 32'h8000_0000;
        m_hi = '0;
      end else if (o == 3) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = 32'(q);
        m_hi = 32'(r);
      end else begin
        m_lo = 32'(ua / ub);
        m_hi = 32'(ua % ub);
      end
      return W + 1;
    end
    if (o == 5) m_hi = a;
    if (o == 6) m_lo = a;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge, count busy cycles, check HI/LO after
  task automatic run(input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit inject);
    int exp_n;
    int n;
    exp_n = model(o, a, b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    n     = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1;
        op    = 4'd5;
        rs    = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      op    = 4'd0;
    end
    chk($sformatf("busy_cycles op%0d", o), 64'(n), 64'(exp_n));
    chk($sformatf("hi op%0d", o), {32'b0, hi}, {32'b0, m_hi});
    chk($sformatf("lo op%0d", o), {32'b0, lo}, {32'b0, m_lo});
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
    rs     = '0;
    rt     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run(4'd1, -32'sd3, 32'd7, 1'b0);
    chk("tp_mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("tp_mult_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    run(4'd3, -32'sd7, 32'd2, 1'b0);
    chk("tp_div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("tp_div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    run(4'd4, 32'd5, 32'd0, 1'b0);
    chk("tp_dz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
    chk("tp_dz_hi", {32'b0, hi}, 64'd5);
    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("tp_ovf_lo", {32'b0, lo}, 64'h8000_0000);
    chk("tp_ovf_hi", {32'b0, hi}, 64'd0);
    run(4'd5, 32'h1234, 32'd0, 1'b0);

    start = 1'b1;
    op    = 4'd2;
    rs    = 32'hFFFF_FFFF;
    rt    = 32'd2;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    chk("cx_busy1", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("cx_busy2", {63'b0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cx_busy_fall", {63'b0, busy}, 64'd0);
    chk("cx_hi", {32'b0, hi}, 64'h1234);
    chk("cx_lo", {32'b0, lo}, {32'b0, m_lo});

    start  = 1'b1;
    cancel = 1'b1;
    op     = 4'd5;
    rs     = 32'hBEEF;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    op     = 4'd0;
    chk("cs_busy", {63'b0, busy}, 64'd0);
    chk("cs_hi", {32'b0, hi}, 64'h1234);

    run(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(4'd5, 32'd0, 32'd0, 1'b0);
    run(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
    chk("madd_hi", {32'b0, hi}, 64'd1);
    chk("madd_lo", {32'b0, lo}, 64'd0);
`else
    chk("madd_off_hi", {32'b0, hi}, 64'd0);
    chk("madd_off_lo", {32'b0, lo}, 64'hFFFF_FFFF);
`endif

    run(4'd1, 32'd3, 32'd4, 1'b1);
    chk("inj_lo", {32'b0, lo}, 64'd12);

    for (int i = 0; i < 150; i++)
      run(4'($urandom_range(0, 15)), rnd(), rnd(), 1'($urandom_range(0, 7) == 0));

    run(4'd1, -32'sd3, 32'd7, 1'b0);
    start = 1'b1;
    op    = 4'd3;
    rs    = 32'd1000;
    rt    = 32'd7;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    repeat (9) @(negedge clk);
    chk("rd_busy_before", {63'b0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rd_busy", {63'b0, busy}, 64'd0);
    chk("rd_hi", {32'b0, hi}, 64'd0);
    chk("rd_lo", {32'b0, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(4'd4, 32'd100, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
